// File: rtl/controls_pkg.sv
// Shared definitions for the multi-page controls/help overlay: RGB565 colours,
// FSM state and button-id enums, and the on-screen button box geometry.
package controls_pkg;

    // RGB565 colours
    localparam logic [15:0] C_BLACK = 16'h0000;
    localparam logic [15:0] C_WHITE = 16'hFFFF;
    localparam logic [15:0] C_RED   = 16'hF800;
    localparam logic [15:0] C_GREEN = 16'h07E0;
    localparam logic [15:0] C_GREY  = 16'h8410;

    typedef enum logic [1:0] {
        StShow,
        StHilite,
        StExit
    } state_e;

    // Encodings double as box indices 1..5 in the glyph ROM
    typedef enum logic [2:0] {
        BtnNone = 3'd0,
        BtnL    = 3'd1,
        BtnR    = 3'd2,
        BtnU    = 3'd3,
        BtnD    = 3'd4,
        BtnC    = 3'd5
    } btn_id_e;

    // Outer button boxes are 11x9 pixels around their centre
    localparam int NUM_BOXES  = 5;
    localparam int BOX_HALF_W = 5;
    localparam int BOX_HALF_H = 4;

    function automatic int box_cx(input int b);
        case (b)
            1:       return 34;  // L
            2:       return 62;  // R
            default: return 48;  // U, D, C
        endcase
    endfunction

    function automatic int box_cy(input int b);
        case (b)
            3:       return 22;  // U
            4:       return 44;  // D
            default: return 33;  // L, R, C
        endcase
    endfunction

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/controls_glyph_rom.sv
// Combinational pixel classifier for the controls overlay: reports whether
// (x, y) is a glyph/outline pixel of the given page, an arrow pixel, and which
// button box (if any) contains it. Optional page dots: CONTROLS_PAGE_DOTS_EN.
module controls_glyph_rom
    import controls_pkg::*;
#(
    parameter int unsigned WIDTH     = 96,
    parameter int unsigned HEIGHT    = 64,
    parameter int unsigned NUM_PAGES = 3,
    parameter int unsigned PW        = $clog2(NUM_PAGES)
) (
    input  logic [6:0]    i_x,
    input  logic [5:0]    i_y,
    input  logic [PW-1:0] i_page,
    output logic          o_glyph,
    output logic          o_arrow,
    output btn_id_e       o_box_id,
    output logic          o_dot_on,
    output logic          o_dot_cur
);

    // ">>>" made of three filled 4x7 triangles near the bottom-right corner
    localparam int ARROW_X0 = int'(WIDTH) - 18;
    localparam int ARROW_Y  = int'(HEIGHT) - 7;

    int   w_x;
    int   w_y;
    int   w_page;
    int   w_adx;
    int   w_ady;
    int   w_dxa;
    logic w_box_glyph;
    logic w_mark;

    assign w_x    = int'(i_x);
    assign w_y    = int'(i_y);
    assign w_page = int'(i_page);

    // Box membership, box outlines and the page-dependent centre stroke
    always_comb begin
        o_box_id    = BtnNone;
        w_box_glyph = 1'b0;
        w_adx       = 0;
        w_ady       = 0;
        for (int b = 1; b <= NUM_BOXES; b++) begin
            w_adx = abs_i(w_x - box_cx(b));
            w_ady = abs_i(w_y - box_cy(b));
            if (w_adx <= BOX_HALF_W && w_ady <= BOX_HALF_H) begin
                o_box_id    = btn_id_e'(3'(b));
                // centre stroke is 3 wide and grows by 2 rows per page
                w_box_glyph = (w_adx == BOX_HALF_W) || (w_ady == BOX_HALF_H) ||
                              (w_adx <= 1 && w_ady <= w_page);
            end
        end
    end

    // Page marker: page+1 two-pixel-wide bars at the top left, pitch 4
    assign w_mark = (w_y >= 2) && (w_y <= 8) && (w_x >= 4) &&
                    (w_x - 4 <= 4 * w_page + 1) && (((w_x - 4) & 2) == 0);

    assign o_glyph = w_box_glyph | w_mark;

    // Arrow shape, suppressed on the last page
    always_comb begin
        o_arrow = 1'b0;
        w_dxa   = 0;
        if (w_page < int'(NUM_PAGES) - 1) begin
            for (int k = 0; k < 3; k++) begin
                w_dxa = w_x - (ARROW_X0 + 5 * k);
                if (w_dxa >= 0 && w_dxa <= 3 && abs_i(w_y - ARROW_Y) <= w_dxa) begin
                    o_arrow = 1'b1;
                end
            end
        end
    end

`ifdef CONTROLS_PAGE_DOTS_EN
    // 2x2 dots on rows HEIGHT-4..HEIGHT-3, pitch 4, centred horizontally
    localparam int DOT_X0 = int'(WIDTH) / 2 - 2 * int'(NUM_PAGES) + 1;
    localparam int DOT_Y0 = int'(HEIGHT) - 4;

    // Page-dot membership and whether the dot belongs to the current page
    always_comb begin
        o_dot_on  = 1'b0;
        o_dot_cur = 1'b0;
        if (w_y >= DOT_Y0 && w_y <= DOT_Y0 + 1) begin
            for (int k = 0; k < int'(NUM_PAGES); k++) begin
                if (w_x >= DOT_X0 + 4 * k && w_x <= DOT_X0 + 4 * k + 1) begin
                    o_dot_on  = 1'b1;
                    o_dot_cur = (k == w_page);
                end
            end
        end
    end
`else
    assign o_dot_on  = 1'b0;
    assign o_dot_cur = 1'b0;
`endif

endmodule

// File: rtl/controls_screen_pager.sv
// Multi-page controls/help overlay for the 96x64 OLED pixel stream. Buttons
// navigate pages, the pressed button box is briefly highlighted, the ">>>"
// arrow blinks and done pulses when the user leaves the last page.
// Optional page-indicator dots: define CONTROLS_PAGE_DOTS_EN.
module controls_screen_pager
    import controls_pkg::*;
#(
    parameter int unsigned WIDTH         = 96,
    parameter int unsigned HEIGHT        = 64,
    parameter int unsigned NUM_PAGES     = 3,
    parameter int unsigned BLINK_TICKS   = 15,
    parameter int unsigned HILITE_TICKS  = 8,
    parameter logic [15:0] FG_COLOUR     = C_BLACK,
    parameter logic [15:0] BG_COLOUR     = C_WHITE,
    parameter logic [15:0] ARROW_COLOUR  = C_RED,
    parameter logic [15:0] HILITE_COLOUR = C_GREEN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_frame_tick,
    input  logic                         i_btn_l,
    input  logic                         i_btn_r,
    input  logic                         i_btn_u,
    input  logic                         i_btn_d,
    input  logic                         i_btn_c,
    input  logic [6:0]                   i_x,
    input  logic [5:0]                   i_y,
    output logic [15:0]                  o_oled_data,
    output logic [$clog2(NUM_PAGES)-1:0] o_page,
    output logic                         o_done
);

    localparam int unsigned   PW        = $clog2(NUM_PAGES);
    localparam int unsigned   BW        = $clog2(BLINK_TICKS + 1);
    localparam int unsigned   TW        = $clog2(HILITE_TICKS + 1);
    localparam logic [PW-1:0] LAST_PAGE = PW'(NUM_PAGES - 1);

    state_e          r_state;
    logic [PW-1:0]   r_page;
    btn_id_e         r_hl_btn;
    logic [TW-1:0]   r_timer;
    logic [BW-1:0]   r_blink_cnt;
    logic            r_arrow_on;
    logic            r_done;
    logic [15:0]     r_pix;

    logic            w_any;
    logic            w_exit;
    btn_id_e         w_hl_sel;
    logic [PW-1:0]   w_page_nxt;
    logic            w_in_range;
    logic            w_glyph;
    logic            w_arrow;
    btn_id_e         w_box_id;
    logic            w_dot_on;
    logic            w_dot_cur;
    logic [15:0]     w_colour;

    controls_glyph_rom #(
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .NUM_PAGES (NUM_PAGES),
        .PW        (PW)
    ) u_glyph_rom (
        .i_x       (i_x),
        .i_y       (i_y),
        .i_page    (r_page),
        .o_glyph   (w_glyph),
        .o_arrow   (w_arrow),
        .o_box_id  (w_box_id),
        .o_dot_on  (w_dot_on),
        .o_dot_cur (w_dot_cur)
    );

    // Button decode: highlight priority c > r > l > u > d, page step and exit
    always_comb begin
        w_any      = i_btn_l | i_btn_r | i_btn_u | i_btn_d | i_btn_c;
        w_exit     = 1'b0;
        w_page_nxt = r_page;
        if (i_btn_c)      w_hl_sel = BtnC;
        else if (i_btn_r) w_hl_sel = BtnR;
        else if (i_btn_l) w_hl_sel = BtnL;
        else if (i_btn_u) w_hl_sel = BtnU;
        else if (i_btn_d) w_hl_sel = BtnD;
        else              w_hl_sel = BtnNone;

        if (i_btn_c) begin
            if (r_page == LAST_PAGE) w_exit = 1'b1;
            else                     w_page_nxt = r_page + PW'(1);
        end else if (i_btn_l && i_btn_r) begin
            w_page_nxt = r_page;  // opposing presses cancel
        end else if (i_btn_r) begin
            w_page_nxt = (r_page == LAST_PAGE) ? '0 : r_page + PW'(1);
        end else if (i_btn_l) begin
            w_page_nxt = (r_page == '0) ? LAST_PAGE : r_page - PW'(1);
        end
    end

    // Pixel colour for the requested coordinate under the current state
    always_comb begin
        w_in_range = (32'(i_x) < WIDTH) && (32'(i_y) < HEIGHT);
        if (!w_in_range)                                  w_colour = BG_COLOUR;
        else if (r_hl_btn != BtnNone && w_box_id == r_hl_btn) w_colour = HILITE_COLOUR;
        else if (w_glyph)                                 w_colour = FG_COLOUR;
        else if (w_dot_on)                                w_colour = w_dot_cur ? FG_COLOUR : C_GREY;
        else if (w_arrow && r_arrow_on)                   w_colour = ARROW_COLOUR;
        else                                              w_colour = BG_COLOUR;
    end

    // Navigation FSM with highlight timer, arrow blink and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StShow;
            r_page      <= '0;
            r_hl_btn    <= BtnNone;
            r_timer     <= '0;
            r_blink_cnt <= '0;
            r_arrow_on  <= 1'b1;
            r_done      <= 1'b0;
            r_pix       <= BG_COLOUR;
        end else begin
            r_done <= 1'b0;
            r_pix  <= w_colour;

            if (i_frame_tick) begin
                if (r_blink_cnt == BW'(BLINK_TICKS - 1)) begin
                    r_blink_cnt <= '0;
                    r_arrow_on  <= ~r_arrow_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end

            case (r_state)
                StShow, StHilite: begin
                    if (w_any) begin
                        if (w_exit) begin
                            r_state  <= StExit;
                            r_done   <= 1'b1;
                            r_hl_btn <= BtnNone;
                            r_timer  <= '0;
                        end else begin
                            // a press wins over a coincident frame_tick: full reload
                            r_state  <= StHilite;
                            r_timer  <= TW'(HILITE_TICKS);
                            r_hl_btn <= w_hl_sel;
                            if (w_page_nxt != r_page) begin
                                r_page      <= w_page_nxt;
                                r_blink_cnt <= '0;
                                r_arrow_on  <= 1'b1;
                            end
                        end
                    end else if (r_state == StHilite && i_frame_tick) begin
                        if (r_timer <= TW'(1)) begin
                            r_state  <= StShow;
                            r_timer  <= '0;
                            r_hl_btn <= BtnNone;
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                end
                StExit: begin
                    // buttons are ignored for the single exit cycle
                    r_state     <= StShow;
                    r_page      <= '0;
                    r_blink_cnt <= '0;
                    r_arrow_on  <= 1'b1;
                end
                default: begin
                    r_state  <= StShow;
                    r_hl_btn <= BtnNone;
                end
            endcase
        end
    end

    assign o_oled_data = r_pix;
    assign o_page      = r_page;
    assign o_done      = r_done;

endmodule

// File: doc/controls_screen_pager.md
Name: controls_screen_pager

Overview:
- Sequential successor to the single static controls screen.
- Renders a multi-page controls/help overlay on the 96x64 OLED pixel stream.
- Navigation: left/right/centre buttons move between pages; a pressed button is highlighted briefly; the "next" arrow blinks.
- Sits between the debounced button block and the OLED driver's pixel-colour mux. Asserts done when the user leaves the last page.

Parameters:
- WIDTH, 96, visible pixel columns
- HEIGHT, 64, visible pixel rows
- NUM_PAGES, 3, number of help pages (>=2)
- BLINK_TICKS, 15, frame_ticks per arrow on/off half-period (>=1)
- HILITE_TICKS, 8, frame_ticks a pressed-button highlight persists (>=1)
- FG_COLOUR, 16'h0000, glyph/outline colour (RGB565)
- BG_COLOUR, 16'hFFFF, background colour
- ARROW_COLOUR, 16'hF800, blinking ">>>" colour
- HILITE_COLOUR, 16'h07E0, pressed-button fill colour

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse per OLED frame
- btn_l, btn_r, btn_u, btn_d, btn_c  in  1 each  debounced single-cycle press pulses
- x  in  7  pixel column being requested
- y  in  6  pixel row being requested
- oled_data  out  16  registered pixel colour
- page  out  $clog2(NUM_PAGES)  current page index
- done  out  1  one-cycle pulse on exit from last page

Behaviour:
- Reset and clocking: single clock; asynchronous active-low reset.
- Reset values: page=0, done=0, oled_data=BG_COLOUR, FSM=SHOW, arrow_on=1, blink counter=0, highlight timer=0, hl_btn=none.
- Pixel latency: exactly 1 cycle; oled_data(t+1) = colour(x(t), y(t), state(t)).
- Out of range: x>=WIDTH or y>=HEIGHT yields BG_COLOUR.
- Colour priority:
  - HILITE_COLOUR if the pixel is inside the highlighted button's outer box;
  - else FG_COLOUR if the pixel is a glyph/outline pixel of the current page;
  - else ARROW_COLOUR if the pixel is an arrow pixel and arrow_on=1;
  - else BG_COLOUR.
- Arrow: drawn only when page < NUM_PAGES-1.
- FSM states: SHOW, HILITE, EXIT.
  - SHOW: any button pulse -> HILITE; timer=HILITE_TICKS; hl_btn=that button; page update applied in the same cycle.
  - HILITE: timer decrements on each frame_tick; at 0 -> SHOW and hl_btn=none. A new pulse restarts the timer and replaces hl_btn.
  - EXIT: entered when btn_c is pressed while page==NUM_PAGES-1. Pulses done=1 for one cycle, then sets page=0 and goes to SHOW with no highlight.
- Page update rules:
  - btn_r, or btn_c on a non-last page: page+1; wraps NUM_PAGES-1 -> 0 for btn_r only.
  - btn_l: page-1; wraps 0 -> NUM_PAGES-1.
  - btn_u/btn_d: highlight only, no page change.
- Simultaneous pulses:
  - l+r together: page unchanged, hl_btn=r.
  - btn_c has priority over l/r.
  - Highlight priority: c > r > l > u > d.
- Blink: counter increments on frame_tick. When it reaches BLINK_TICKS-1 it clears and arrow_on toggles.
- Page change resets the blink counter and sets arrow_on=1.
- frame_tick coincident with a button pulse: the button event is processed first; the timer loads HILITE_TICKS, no decrement that cycle.
- Reset mid-highlight or mid-EXIT: all state returns to reset values immediately; done never glitches high.

Optional Feature:
- CONTROLS_PAGE_DOTS_EN defined: NUM_PAGES 2x2 dots centred on row HEIGHT-3, spaced 4 px. The current page's dot is FG_COLOUR, the others are filled grey 16'h8410. Dots sit just below glyph priority.
- Undefined: no dots; those pixels follow normal priority.

Decomposition:
- Shared package controls_pkg holds:
  - RGB565 colour constants;
  - FSM state enum (SHOW/HILITE/EXIT);
  - button-id enum (NONE/L/R/U/D/C);
  - button box coordinates (outer 11x9 boxes at centre 48,22 / 48,33 / 48,44 / 34,33 / 62,33).
- Sub-module controls_glyph_rom: purely combinational (x, y, page) -> {glyph, arrow, box_id}. The top level registers its outputs with the state.

Test Plan:
- Reset release, x=10,y=10 on page 0 -> oled_data=16'hFFFF one cycle later; page=0, done=0.
- btn_r x3 with NUM_PAGES=3 -> page 1,2,0. btn_l from 0 -> page 2.
- btn_u, then sample x=48,y=20 -> 16'h07E0. After 8 frame_ticks -> background/glyph colour at the same point.
- Page 2, btn_c -> done=1 for exactly one cycle; page=0; FSM SHOW.
- Page 0, 15 frame_ticks with x=86,y=57 -> RED then WHITE. Page 2 same pixel -> always WHITE.
- btn_l+btn_r same cycle on page 1 -> page stays 1; R box highlighted. Assert rst_n low mid-HILITE -> oled_data=16'hFFFF and timer=0 asynchronously.
